// File: rtl/writeback_regfile_if.sv
// Writeback/regfile bus: per-lane commit requests from the EX/WB register,
// four issue read ports, forwarding outputs and the retire counter.
//   slave  : the register file (consumes commits and read addresses)
//   master : the surrounding pipeline (drives them, observes results)
interface writeback_regfile_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             reg_write1_wb, reg_write2_wb;
  logic [4:0]       rd1_wb, rd2_wb;
  logic [2:0]       au_mul_lsu1_wb, au_mul_lsu2_wb;
  logic [XLEN-1:0]  au1_wb, au2_wb, mul1_wb, mul2_wb, lsu_wb;
  logic [4:0]       rs1_a, rs2_a, rs1_b, rs2_b;
  logic [XLEN-1:0]  rdata1_a, rdata2_a, rdata1_b, rdata2_b;
  logic             fwd_en1, fwd_en2;
  logic [4:0]       fwd_rd1, fwd_rd2;
  logic [XLEN-1:0]  fwd_data1, fwd_data2;
  logic [CNT_W-1:0] retire_count;

  modport slave (
    input  reg_write1_wb, reg_write2_wb, rd1_wb, rd2_wb,
           au_mul_lsu1_wb, au_mul_lsu2_wb, au1_wb, au2_wb,
           mul1_wb, mul2_wb, lsu_wb, rs1_a, rs2_a, rs1_b, rs2_b,
    output rdata1_a, rdata2_a, rdata1_b, rdata2_b,
           fwd_en1, fwd_en2, fwd_rd1, fwd_rd2, fwd_data1, fwd_data2,
           retire_count
  );

  modport master (
    output reg_write1_wb, reg_write2_wb, rd1_wb, rd2_wb,
           au_mul_lsu1_wb, au_mul_lsu2_wb, au1_wb, au2_wb,
           mul1_wb, mul2_wb, lsu_wb, rs1_a, rs2_a, rs1_b, rs2_b,
    input  rdata1_a, rdata2_a, rdata1_b, rdata2_b,
           fwd_en1, fwd_en2, fwd_rd1, fwd_rd2, fwd_data1, fwd_data2,
           retire_count
  );
endinterface

// File: rtl/writeback_regfile.sv
// Dual-lane writeback stage + 32x32 architectural register file.
//   clk, rst_n : core clock, synchronous active-low reset
//   wb (slave) : lane commit requests, 4 bypassed combinational read ports,
//                forwarding outputs, registered retired-write counter
// Lane 2 is younger in program order and wins same-rd conflicts, both in
// the array and on the read bypass.

// Per-lane source select and commit qualification.
module writeback_lane #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [AW-1:0]   rd_i,
  input  logic [2:0]      sel_i,
  input  logic [XLEN-1:0] au_i,
  input  logic [XLEN-1:0] mul_i,
  input  logic [XLEN-1:0] lsu_i,
  output logic            en_o,
  output logic [XLEN-1:0] data_o
);
  logic sel_ok;

  // One-hot source code; any other pattern kills the lane.
  always_comb begin
    data_o = '0;
    sel_ok = 1'b1;
    case (sel_i)
      3'b001:  data_o = au_i;
      3'b010:  data_o = mul_i;
      3'b100:  data_o = lsu_i;
      default: sel_ok = 1'b0;
    endcase
  end

  // Reset gating keeps the bypass quiet while rst_n is low.
  assign en_o = rst_ni & we_i & sel_ok & (rd_i != '0);
endmodule

module writeback_regfile #(
  parameter int XLEN  = 32,
  parameter int REGS  = 32,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst_n,
  writeback_regfile_if.slave wb
);
  localparam int NUM_LANES = 2;
  localparam int NUM_RP    = 4;
  localparam int AW        = 5;

  logic [NUM_LANES-1:0]            ln_we, ln_en;
  logic [NUM_LANES-1:0][AW-1:0]    ln_rd;
  logic [NUM_LANES-1:0][2:0]       ln_sel;
  logic [NUM_LANES-1:0][XLEN-1:0]  ln_au, ln_mul, ln_data;

  logic [NUM_RP-1:0][AW-1:0]       rp_addr;
  logic [NUM_RP-1:0][XLEN-1:0]     rp_data;

  logic [XLEN-1:0]  rf_q [REGS];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Index 1 = lane 2 (younger).
  assign ln_we  = {wb.reg_write2_wb, wb.reg_write1_wb};
  assign ln_rd  = {wb.rd2_wb, wb.rd1_wb};
  assign ln_sel = {wb.au_mul_lsu2_wb, wb.au_mul_lsu1_wb};
  assign ln_au  = {wb.au2_wb, wb.au1_wb};
  assign ln_mul = {wb.mul2_wb, wb.mul1_wb};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    writeback_lane #(.XLEN(XLEN), .AW(AW)) u_lane (
      .rst_ni (rst_n),
      .we_i   (ln_we[l]),
      .rd_i   (ln_rd[l]),
      .sel_i  (ln_sel[l]),
      .au_i   (ln_au[l]),
      .mul_i  (ln_mul[l]),
      .lsu_i  (wb.lsu_wb),
      .en_o   (ln_en[l]),
      .data_o (ln_data[l])
    );
  end

  assign wb.fwd_en1   = ln_en[0];
  assign wb.fwd_en2   = ln_en[1];
  assign wb.fwd_rd1   = ln_rd[0];
  assign wb.fwd_rd2   = ln_rd[1];
  assign wb.fwd_data1 = ln_data[0];
  assign wb.fwd_data2 = ln_data[1];

  // Lanes applied in ascending order so the last NBA (lane 2) wins on a
  // same-rd collision. en already excludes x0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) rf_q[i] <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++)
        if (ln_en[l]) rf_q[ln_rd[l]] <= ln_data[l];
    end
  end

  // Read ports with write-through bypass; later lane overrides earlier.
  assign rp_addr = {wb.rs2_b, wb.rs1_b, wb.rs2_a, wb.rs1_a};

  always_comb begin
    rp_data = '0;
    for (int p = 0; p < NUM_RP; p++) begin
      rp_data[p] = rf_q[rp_addr[p]];
      for (int l = 0; l < NUM_LANES; l++)
        if (ln_en[l] && ln_rd[l] == rp_addr[p]) rp_data[p] = ln_data[l];
      if (rp_addr[p] == '0) rp_data[p] = '0;
    end
  end

  assign wb.rdata1_a = rp_data[0];
  assign wb.rdata2_a = rp_data[1];
  assign wb.rdata1_b = rp_data[2];
  assign wb.rdata2_b = rp_data[3];

  // Retired-write counter, free-running wrap.
  always_comb begin
    cnt_d = cnt_q;
    for (int l = 0; l < NUM_LANES; l++) cnt_d = cnt_d + CNT_W'(ln_en[l]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign wb.retire_count = cnt_q;
endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  writeback_regfile_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  writeback_regfile #(.XLEN(XLEN), .REGS(32), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus)
  );

  typedef struct {
    logic        we1; logic [2:0] sel1; logic [4:0] rd1; logic [31:0] d1;
    logic        we2; logic [2:0] sel2; logic [4:0] rd2; logic [31:0] d2;
    logic [31:0] lsu;
    logic [4:0]  ra, rb;
    logic [31:0] exp_a, exp_b;
    logic        en1, en2;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs [14];
  vec_t exp_q [$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // The idle source is driven with the complement so a wrong mux pick shows.
  task automatic drive(input vec_t v);
    bus.reg_write1_wb  = v.we1;  bus.au_mul_lsu1_wb = v.sel1; bus.rd1_wb = v.rd1;
    bus.au1_wb  = (v.sel1 == 3'b010) ? ~v.d1 : v.d1;
    bus.mul1_wb = (v.sel1 == 3'b010) ? v.d1 : ~v.d1;
    bus.reg_write2_wb  = v.we2;  bus.au_mul_lsu2_wb = v.sel2; bus.rd2_wb = v.rd2;
    bus.au2_wb  = (v.sel2 == 3'b010) ? ~v.d2 : v.d2;
    bus.mul2_wb = (v.sel2 == 3'b010) ? v.d2 : ~v.d2;
    bus.lsu_wb = v.lsu;
    bus.rs1_a = v.ra; bus.rs2_b = v.ra;
    bus.rs2_a = v.rb; bus.rs1_b = v.rb;
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    drive(v);
    exp_q.push_back(v);
    #1;
    e = exp_q[0];
    chk($sformatf("v%0d rdata1_a", idx), bus.rdata1_a, e.exp_a);
    chk($sformatf("v%0d rdata2_b", idx), bus.rdata2_b, e.exp_a);
    chk($sformatf("v%0d rdata2_a", idx), bus.rdata2_a, e.exp_b);
    chk($sformatf("v%0d rdata1_b", idx), bus.rdata1_b, e.exp_b);
    chk($sformatf("v%0d fwd_en1", idx), 32'(bus.fwd_en1), 32'(e.en1));
    chk($sformatf("v%0d fwd_en2", idx), 32'(bus.fwd_en2), 32'(e.en2));
    chk($sformatf("v%0d fwd_rd1", idx), 32'(bus.fwd_rd1), 32'(e.rd1));
    chk($sformatf("v%0d fwd_rd2", idx), 32'(bus.fwd_rd2), 32'(e.rd2));
    if (e.en1) chk($sformatf("v%0d fwd_data1", idx), bus.fwd_data1, (e.sel1 == 3'b100) ? e.lsu : e.d1);
    if (e.en2) chk($sformatf("v%0d fwd_data2", idx), bus.fwd_data2, (e.sel2 == 3'b100) ? e.lsu : e.d2);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL v%0d scoreboard empty", idx);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("v%0d retire_count", idx), 32'(bus.retire_count), 32'(e.cnt));
    end
  endtask

  task automatic idle();
    bus.reg_write1_wb = 1'b0; bus.au_mul_lsu1_wb = 3'b000; bus.rd1_wb = 5'd0;
    bus.au1_wb = '0; bus.mul1_wb = '0;
    bus.reg_write2_wb = 1'b0; bus.au_mul_lsu2_wb = 3'b000; bus.rd2_wb = 5'd0;
    bus.au2_wb = '0; bus.mul2_wb = '0; bus.lsu_wb = '0;
    bus.rs1_a = '0; bus.rs2_a = '0; bus.rs1_b = '0; bus.rs2_b = '0;
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 1; a < 32; a++) begin
      bus.rs1_a = 5'(a); bus.rs2_a = 5'(a); bus.rs1_b = 5'(a); bus.rs2_b = 5'(a);
      #1;
      chk($sformatf("%s x%0d rdata1_a", tag, a), bus.rdata1_a, 32'h0);
      chk($sformatf("%s x%0d rdata2_a", tag, a), bus.rdata2_a, 32'h0);
      chk($sformatf("%s x%0d rdata1_b", tag, a), bus.rdata1_b, 32'h0);
      chk($sformatf("%s x%0d rdata2_b", tag, a), bus.rdata2_b, 32'h0);
    end
  endtask

  initial begin
    vec_t v;
    logic [3:0] cnt_m;

    //           we1  sel1    rd1   d1            we2  sel2    rd2   d2            lsu           ra    rb    exp_a         exp_b         en1  en2  cnt
    vecs[0]  = '{1'b1,3'b001,5'd5,32'h12345678, 1'b0,3'b000,5'd0,32'h0,        32'h0,        5'd5, 5'd0, 32'h12345678, 32'h0,        1'b1,1'b0,4'd1};
    vecs[1]  = '{1'b0,3'b000,5'd0,32'h0,        1'b0,3'b000,5'd0,32'h0,        32'h0,        5'd5, 5'd7, 32'h12345678, 32'h0,        1'b0,1'b0,4'd1};
    vecs[2]  = '{1'b1,3'b010,5'd7,32'hAAAA0000, 1'b1,3'b001,5'd7,32'h00005555, 32'h0,        5'd7, 5'd5, 32'h00005555, 32'h12345678, 1'b1,1'b1,4'd3};
    vecs[3]  = '{1'b0,3'b000,5'd0,32'h0,        1'b0,3'b000,5'd0,32'h0,        32'h0,        5'd7, 5'd5, 32'h00005555, 32'h12345678, 1'b0,1'b0,4'd3};
    vecs[4]  = '{1'b0,3'b000,5'd0,32'h0,        1'b1,3'b100,5'd0,32'h0,        32'hFFFFFFFF, 5'd0, 5'd7, 32'h0,        32'h00005555, 1'b0,1'b0,4'd3};
    vecs[5]  = '{1'b0,3'b000,5'd0,32'h0,        1'b1,3'b011,5'd3,32'h0000CAFE, 32'h0,        5'd3, 5'd5, 32'h0,        32'h12345678, 1'b0,1'b0,4'd3};
    vecs[6]  = '{1'b1,3'b100,5'd4,32'h0,        1'b1,3'b100,5'd6,32'h0,        32'h0BADF00D, 5'd4, 5'd6, 32'h0BADF00D, 32'h0BADF00D, 1'b1,1'b1,4'd5};
    vecs[7]  = '{1'b0,3'b000,5'd0,32'h0,        1'b0,3'b000,5'd0,32'h0,        32'h0,        5'd6, 5'd4, 32'h0BADF00D, 32'h0BADF00D, 1'b0,1'b0,4'd5};
    vecs[8]  = '{1'b0,3'b001,5'd8,32'h00000001, 1'b0,3'b000,5'd0,32'h0,        32'h0,        5'd8, 5'd7, 32'h0,        32'h00005555, 1'b0,1'b0,4'd5};
    vecs[9]  = '{1'b1,3'b001,5'd8,32'h00000011, 1'b1,3'b010,5'd9,32'h00000022, 32'h0,        5'd8, 5'd9, 32'h00000011, 32'h00000022, 1'b1,1'b1,4'd7};
    vecs[10] = '{1'b0,3'b000,5'd0,32'h0,        1'b0,3'b000,5'd0,32'h0,        32'h0,        5'd9, 5'd8, 32'h00000022, 32'h00000011, 1'b0,1'b0,4'd7};
    vecs[11] = '{1'b1,3'b001,5'd9,32'h00000033, 1'b0,3'b000,5'd0,32'h0,        32'h0,        5'd9, 5'd8, 32'h00000033, 32'h00000011, 1'b1,1'b0,4'd8};
    vecs[12] = '{1'b0,3'b000,5'd0,32'h0,        1'b1,3'b000,5'd9,32'h00000044, 32'h0,        5'd9, 5'd0, 32'h00000033, 32'h0,        1'b0,1'b0,4'd8};
    vecs[13] = '{1'b1,3'b001,5'd0,32'h00000077, 1'b0,3'b000,5'd0,32'h0,        32'h0,        5'd0, 5'd9, 32'h0,        32'h00000033, 1'b0,1'b0,4'd8};

    // Initial reset with a write request pending: must be discarded.
    idle();
    rst_n = 1'b0;
    bus.reg_write1_wb = 1'b1; bus.au_mul_lsu1_wb = 3'b001; bus.rd1_wb = 5'd5; bus.au1_wb = 32'h5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset fwd_en1", 32'(bus.fwd_en1), 32'h0);
    chk("reset fwd_en2", 32'(bus.fwd_en2), 32'h0);
    chk("reset retire_count", 32'(bus.retire_count), 32'h0);
    bus.rs1_a = 5'd5;
    #1 chk("reset rdata x5 in reset", bus.rdata1_a, 32'h0);
    idle();
    rst_n = 1'b1;
    read_all_zero("post-reset");

    for (int i = 0; i < 14; i++) apply(vecs[i], i);

    // Mid-operation reset: x9 written, then reset edge with x10 write pending.
    v = '{1'b1,3'b001,5'd9,32'hDEADBEEF, 1'b0,3'b000,5'd0,32'h0, 32'h0,
          5'd9, 5'd8, 32'hDEADBEEF, 32'h00000011, 1'b1,1'b0,4'd9};
    apply(v, 14);
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    bus.reg_write1_wb = 1'b1; bus.au_mul_lsu1_wb = 3'b001; bus.rd1_wb = 5'd10; bus.au1_wb = 32'h1;
    bus.rs1_a = 5'd10; bus.rs2_a = 5'd9;
    #1;
    chk("midrst fwd_en1", 32'(bus.fwd_en1), 32'h0);
    chk("midrst rdata x10 no bypass", bus.rdata1_a, 32'h0);
    chk("midrst rdata x9 array", bus.rdata2_a, 32'hDEADBEEF);
    @(posedge clk);
    #1 chk("midrst retire_count", 32'(bus.retire_count), 32'h0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    read_all_zero("midrst");

    // Counter wrap with CNT_W=4: 7 double commits + 1 single = 15, then +1 -> 0.
    cnt_m = 4'd0;
    for (int i = 0; i < 9; i++) begin
      v = '{1'b1,3'b001,5'd1,32'(i + 100), (i < 7),3'b010,5'd2,32'(i + 200), 32'h0,
            5'd1, 5'd2, 32'(i + 100), 32'h0, 1'b1, (i < 7), 4'd0};
      v.exp_b = (i < 7) ? 32'(i + 200) : 32'(6 + 200);
      cnt_m = cnt_m + 4'd1 + ((i < 7) ? 4'd1 : 4'd0);
      v.cnt = cnt_m;
      apply(v, 100 + i);
    end
    chk("wrap retire_count", 32'(bus.retire_count), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
